// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder standing in for the WM8731 control port; decodes
// 3-byte register writes into a small register file for loopback bring-up.
module i2c_codec_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_low,
  output logic       o_wr_stb,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [3:0] i_rd_idx,
  output logic [8:0] o_rd_data,
  output logic [7:0] o_wr_count,
  output logic       o_busy
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam logic [ADDR_W-1:0] RESET_REG = 7'h0F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_BYTE1,
    S_ACK_1,
    S_BYTE2,
    S_ACK_2,
    S_IGNORE
  } state_t;

  logic              scl_meta, scl_sync, scl_prev;
  logic              sda_meta, sda_sync, sda_prev;
  logic              scl_rise, scl_fall, start_cond, stop_cond;
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] reg_addr;
  logic              data_msb;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Synchronizers reset to the idle-bus level so reset release looks like a quiet bus
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= i_scl;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= i_sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  assign scl_rise   = scl_sync & ~scl_prev;
  assign scl_fall   = ~scl_sync & scl_prev;
  assign start_cond = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_cond  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  assign byte_in   = {shreg, sda_sync};
  assign wr_word   = {data_msb, byte_in};
  assign o_rd_data = regs[i_rd_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      reg_addr   <= 7'd0;
      data_msb   <= 1'b0;
      o_sda_low  <= 1'b0;
      o_wr_stb   <= 1'b0;
      o_wr_addr  <= 7'd0;
      o_wr_data  <= 9'd0;
      o_wr_count <= 8'd0;
      o_busy     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      o_wr_stb <= 1'b0;
      if (start_cond) begin
        state     <= S_ADDR;
        bit_cnt   <= 3'd0;
        shreg     <= 7'd0;
        o_sda_low <= 1'b0;
        o_busy    <= 1'b1;
      end else if (stop_cond) begin
        state     <= S_IDLE;
        o_sda_low <= 1'b0;
        o_busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_BYTE1, S_BYTE2: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == S_ADDR) begin
                  state <= (byte_in == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                end else if (state == S_BYTE1) begin
                  reg_addr <= byte_in[7:1];
                  data_msb <= byte_in[0];
                  state    <= S_ACK_1;
                end else begin
                  // Commit on the last data bit, before the ACK slot
                  o_wr_stb  <= 1'b1;
                  o_wr_addr <= reg_addr;
                  o_wr_data <= wr_word;
                  if (reg_addr == RESET_REG) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                  end else begin
                    regs[reg_addr[IDX_W-1:0]] <= wr_word;
                  end
                  if (o_wr_count != {CNT_W{1'b1}}) o_wr_count <= o_wr_count + 8'd1;
                  state <= S_ACK_2;
                end
              end
            end
          end
          // o_sda_low doubles as the ACK phase flag: first fall drives, second releases
          S_ACK_A, S_ACK_1, S_ACK_2: begin
            if (scl_fall) begin
              if (!o_sda_low) begin
                o_sda_low <= 1'b1;
              end else begin
                o_sda_low <= 1'b0;
                state <= (state == S_ACK_A) ? S_BYTE1 :
                         (state == S_ACK_1) ? S_BYTE2 : S_IGNORE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
